// File: rtl/pcie_tl_pkg.sv
// Shared transaction-layer FIFO constants, arbiter FSM state type and VC rotation helper.
package pcie_tl_pkg;

  localparam int LINE_SIZE    = 12;
  localparam int FIFO_DEPTH   = 8;
  localparam int ALMOST_FULL  = 6;
  localparam int ALMOST_EMPTY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  function automatic logic [1:0] next_vc(input logic [1:0] vc, input int num_vc);
    return (int'(vc) == num_vc - 1) ? 2'd0 : vc + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible VC at or after ptr, wrapping at NUM_VC.
module rr_pick #(
  parameter int NUM_VC = 4
) (
  input  logic [NUM_VC-1:0] elig,
  input  logic [1:0]        ptr,
  output logic              valid,
  output logic [1:0]        idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!valid && elig[(int'(ptr) + k) % NUM_VC]) begin
        valid = 1'b1;
        idx   = 2'((int'(ptr) + k) % NUM_VC);
      end
    end
  end

endmodule

// File: rtl/vc_fifo_arbiter.sv
// Round-robin, burst-bounded arbiter draining NUM_VC VC FIFOs into one shared output FIFO.
// Optional push_count statistics port is enabled by defining ARB_STATS_EN.
module vc_fifo_arbiter
  import pcie_tl_pkg::*;
#(
  parameter int LINE_SIZE = pcie_tl_pkg::LINE_SIZE,
  parameter int NUM_VC    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC-1:0]           vc_empty,
  input  logic [NUM_VC-1:0]           vc_almost_empty,
  input  logic [NUM_VC*LINE_SIZE-1:0] vc_data,
  input  logic                        out_almost_full,
  output logic [NUM_VC-1:0]           vc_pop,
  output logic                        out_push,
  output logic [LINE_SIZE-1:0]        out_data,
  output logic [1:0]                  grant_id,
`ifdef ARB_STATS_EN
  output logic [15:0]                 push_count,
`endif
  output logic                        busy
);

  // state | meaning
  // IDLE  | nothing granted; pops the first eligible VC at/after rr_ptr
  // BURST | popping the granted VC until BURST_LEN, empty, or backpressure
  // STALL | output almost full; grant and burst count held, no pops
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  arb_state_t        state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [NUM_VC-1:0] pop_q, pop_d, elig;
  logic [1:0]        pick_ptr, pick_idx;
  logic              pick_valid, launch, rotate, burst_more, burst_done;

  // A VC popped last cycle still shows pre-pop flags, so it needs two lines to be safe.
  assign elig       = ~vc_empty & (~pop_q | ~vc_almost_empty);
  assign pick_ptr   = (state_q == IDLE) ? rr_ptr_q : next_vc(grant_q, NUM_VC);
  assign burst_more = (burst_q != BURST_MAX) && elig[grant_q];
  assign burst_done = (burst_q == BURST_MAX) || vc_empty[grant_q];

  rr_pick #(.NUM_VC(NUM_VC)) u_rr_pick (
    .elig  (elig),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    pop_d    = '0;
    launch   = 1'b0;
    rotate   = 1'b0;
    unique case (state_q)
      IDLE: launch = !out_almost_full && pick_valid;
      BURST, STALL: begin
        if (out_almost_full) begin
          state_d = STALL;
        end else if (burst_more) begin
          pop_d[grant_q] = 1'b1;
          burst_d        = burst_q + 1'b1;
          state_d        = BURST;
        end else if (burst_done) begin
          rotate = 1'b1;
        end else begin
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rotate) begin
      rr_ptr_d = next_vc(grant_q, NUM_VC);
      state_d  = IDLE;
      launch   = pick_valid;
    end
    if (launch) begin
      pop_d           = '0;
      pop_d[pick_idx] = 1'b1;
      grant_d         = pick_idx;
      burst_d         = CNT_W'(1);
      state_d         = BURST;
    end
    if (reset) pop_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      burst_q  <= '0;
      pop_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      pop_q    <= pop_d;
    end
  end

  // grant_q always names the VC popped in the previous cycle, so it doubles as the data select.
  assign vc_pop   = pop_d;
  assign out_push = (|pop_q) && !reset;
  assign out_data = out_push ? vc_data[int'(grant_q)*LINE_SIZE +: LINE_SIZE] : '0;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) push_count <= '0;
    else if (out_push && push_count != 16'hFFFF) push_count <= push_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vc_fifo_arbiter.sv
// Directed scoreboard bench for vc_fifo_arbiter with behavioural VC and output FIFO models.
module tb_vc_fifo_arbiter;
  import pcie_tl_pkg::*;

  localparam int NV = 4;
  localparam int LS = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NV-1:0]    vc_empty, vc_almost_empty;
  logic [NV*LS-1:0] vc_data;
  logic             out_almost_full;
  logic [NV-1:0]    vc_pop;
  logic             out_push;
  logic [LS-1:0]    out_data;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef ARB_STATS_EN
  logic [15:0]      push_count;
`endif

  vc_fifo_arbiter #(.LINE_SIZE(LS), .NUM_VC(NV), .BURST_LEN(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .vc_empty        (vc_empty),
    .vc_almost_empty (vc_almost_empty),
    .vc_data         (vc_data),
    .out_almost_full (out_almost_full),
    .vc_pop          (vc_pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .grant_id        (grant_id),
`ifdef ARB_STATS_EN
    .push_count      (push_count),
`endif
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {int c; int vc;} pop_t;
  typedef struct {logic [LS-1:0] d; logic [1:0] g;} exp_t;

  logic [LS-1:0] vcq [NV][$];
  logic [LS-1:0] dreg [NV];
  logic [LS-1:0] outq [$];
  pop_t          plog [$];
  exp_t          expq [$];
  bit            drain = 1'b1;
  bit            af_force = 1'b0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic update_flags();
    for (int i = 0; i < NV; i++) begin
      vc_empty[i]        = (vcq[i].size() == 0);
      vc_almost_empty[i] = (vcq[i].size() <= ALMOST_EMPTY);
      vc_data[i*LS +: LS] = dreg[i];
    end
    out_almost_full = af_force || (outq.size() >= ALMOST_FULL);
  endtask

  // FIFO models: capture at the edge, apply 1 ns later so the DUT never races the model.
  always @(posedge clk) begin
    logic [NV-1:0] p;
    logic          ps;
    logic [LS-1:0] d;
    p  = vc_pop;
    ps = out_push;
    d  = out_data;
    for (int i = 0; i < NV; i++) if (p[i]) plog.push_back('{cyc, i});
    cyc++;
    #1;
    for (int i = 0; i < NV; i++) if (p[i] && vcq[i].size() > 0) dreg[i] = vcq[i].pop_front();
    if (drain && outq.size() > 0) void'(outq.pop_front());
    if (ps) begin
      n_cmp++;
      if (outq.size() >= FIFO_DEPTH) begin
        n_bad++;
        $display("FAIL out_overflow: occupancy %0d, required below %0d", outq.size(), FIFO_DEPTH);
      end
      outq.push_back(d);
    end
    update_flags();
  end

  // Monitor: every push is popped against the scoreboard; every pop is protocol-checked.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_push) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL push_unexpected: got data=%03h grant=%0d, required no push", out_data, grant_id);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.d || grant_id !== e.g) begin
            n_bad++;
            $display("FAIL push_data: got data=%03h grant=%0d, required data=%03h grant=%0d",
                     out_data, grant_id, e.d, e.g);
          end
        end
      end
      if (vc_pop != '0) begin
        n_cmp++;
        if (!$onehot(vc_pop) || (vc_pop & vc_empty) != '0) begin
          n_bad++;
          $display("FAIL pop_protocol: got vc_pop=%b vc_empty=%b, required one-hot to non-empty", vc_pop, vc_empty);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic start_test();
    reset    = 1'b1;
    af_force = 1'b0;
    drain    = 1'b1;
    expq.delete();
    plog.delete();
    outq.delete();
    for (int i = 0; i < NV; i++) begin
      vcq[i].delete();
      dreg[i] = '0;
    end
    update_flags();
    tick(2);
  endtask

  task automatic load(input int vc, input int n, input int base);
    for (int k = 0; k < n; k++) vcq[vc].push_back(LS'(base + k));
    update_flags();
  endtask

  task automatic expect_run(input int vc, input int base, input int n);
    for (int k = 0; k < n; k++) expq.push_back('{LS'(base + k), 2'(vc)});
  endtask

  task automatic wait_done(input string name, input int budget);
    int t;
    t = 0;
    while ((expq.size() != 0 || busy) && t < budget) begin
      tick();
      t++;
    end
    check(name, (t < budget), 1);
    tick(2);
  endtask

  task automatic wait_pops(input string name, input int n);
    int t;
    t = 0;
    while (plog.size() < n && t < 60) begin
      tick();
      t++;
    end
    check(name, (plog.size() >= n), 1);
  endtask

  initial begin
    int on_c, off_c;

    // Reset state, with data waiting so the reset gating of vc_pop is exercised.
    start_test();
    load(3, 2, 'h300);
    #1;
    check("rst_vc_pop", vc_pop, 0);
    check("rst_out_push", out_push, 0);
    check("rst_out_data", out_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);

    // Single VC: pop, pop, almost_empty bubble, pop.
    start_test();
    load(2, 3, 'h0A1);
    expect_run(2, 'h0A1, 3);
    reset = 1'b0;
    wait_done("t1_timeout", 40);
    check("t1_pop_count", plog.size(), 3);
    if (plog.size() == 3) begin
      check("t1_second_pop", plog[1].c - plog[0].c, 1);
      check("t1_third_pop", plog[2].c - plog[0].c, 3);
      check("t1_pop_vc", plog[2].vc, 2);
    end
    check("t1_grant", grant_id, 2);

    // Round robin: 4 VCs x 8 lines, bursts of 4, no gap between bursts.
    start_test();
    for (int v = 0; v < NV; v++) load(v, 8, v * 256);
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < NV; v++) expect_run(v, v * 256 + r * 4, 4);
    reset = 1'b0;
    wait_done("t2_timeout", 200);
    check("t2_pop_count", plog.size(), 32);
    for (int i = 1; i < plog.size(); i++)
      if (plog[i].vc != plog[i-1].vc) check("t2_burst_gap", plog[i].c - plog[i-1].c, 1);

    // Backpressure after the 2nd pop of a burst.
    start_test();
    load(0, 8, 'h000);
    load(1, 8, 'h100);
    expect_run(0, 'h000, 4);
    expect_run(1, 'h100, 4);
    expect_run(0, 'h004, 4);
    expect_run(1, 'h104, 4);
    reset = 1'b0;
    wait_pops("t3_first_pops", 2);
    af_force = 1'b1;
    update_flags();
    on_c = cyc;
    tick();
    check("t3_stall_busy", busy, 1);
    check("t3_stall_pop", vc_pop, 0);
    check("t3_stall_grant", grant_id, 0);
    tick(4);
    af_force = 1'b0;
    update_flags();
    off_c = cyc;
    wait_done("t3_timeout", 120);
    check("t3_pop_count", plog.size(), 16);
    if (plog.size() == 16) begin
      check("t3_second_pop", plog[1].c, on_c - 1);
      check("t3_resume", plog[2].c, off_c);
      check("t3_resume2", plog[3].c, off_c + 1);
      check("t3_rotate_vc", plog[4].vc, 1);
      check("t3_rotate_cyc", plog[4].c, off_c + 2);
    end

    // VC0 empties mid-burst: rotate to VC1 without popping an empty FIFO.
    start_test();
    load(0, 2, 'h000);
    load(1, 5, 'h100);
    expect_run(0, 'h000, 2);
    expect_run(1, 'h100, 5);
    reset = 1'b0;
    wait_done("t4_timeout", 60);
    check("t4_pop_count", plog.size(), 7);
    if (plog.size() == 7) begin
      check("t4_rotate_vc", plog[2].vc, 1);
      check("t4_rotate_gap", plog[2].c - plog[1].c, 1);
    end

    // Reset in the second VC1 burst (rr_ptr already moved to 2).
    start_test();
    load(1, 8, 'h100);
    expect_run(1, 'h100, 8);
    reset = 1'b0;
    wait_pops("t5_pre_pops", 6);
    check("t5_pre_busy", busy, 1);
    reset = 1'b1;
    expq.delete();
    tick();
    check("t5_rst_pop", vc_pop, 0);
    check("t5_rst_push", out_push, 0);
    check("t5_rst_grant", grant_id, 0);
    check("t5_rst_busy", busy, 0);
    for (int i = 0; i < NV; i++) vcq[i].delete();
    plog.delete();
    load(0, 2, 'h000);
    load(3, 2, 'h300);
    expect_run(0, 'h000, 2);
    expect_run(3, 'h300, 2);
    reset = 1'b0;
    wait_done("t5_timeout", 60);
    check("t5_pop_count", plog.size(), 4);
    if (plog.size() > 0) check("t5_first_vc", plog[0].vc, 0);

`ifdef ARB_STATS_EN
    start_test();
    check("st_rst_count", push_count, 0);
    load(0, 8, 'h000);
    load(1, 8, 'h100);
    load(2, 4, 'h200);
    expect_run(0, 'h000, 4);
    expect_run(1, 'h100, 4);
    expect_run(2, 'h200, 4);
    expect_run(0, 'h004, 4);
    expect_run(1, 'h104, 4);
    reset = 1'b0;
    wait_done("st_timeout", 120);
    check("st_push_count", push_count, 20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
